alignement_marker_lane_rx: RTL



---
 rtl/alignement_marker_pkg.sv | 41 ++++
 rtl/alignement_marker_lane_rx_if.sv | 28 ++
 rtl/alignement_marker_match.sv | 19 +
 rtl/alignement_marker_lane_rx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alignement_marker_pkg.sv
// Shared alignment-marker definitions for the 40GBASE-R lane TX inserter and RX lock.
package alignement_marker_pkg;

  localparam int HEAD_W        = 2;
  localparam int DATA_W        = 64;
  localparam int LANE_N        = 4;
  localparam int LANE_W        = $clog2(LANE_N);
  localparam int AM_PERIOD_DEF = 16384;

  // Markers are control blocks.
  localparam logic [HEAD_W-1:0] AM_SYNC_HEAD = 2'b10;

  // BIP3 (byte 3) and BIP7 (byte 7) carry parity, not pattern.
  localparam logic [DATA_W-1:0] AM_BIP_MASK = 64'hFF00_0000_FF00_0000;

  // Per-lane pattern bytes packed as {b6,b5,b4,b2,b1,b0}.
  localparam logic [47:0] AM_PATTERN [LANE_N] = '{
    48'hB8896F_477690,
    48'h193B0F_E6C4F0,
    48'h649A3A_9B65C5,
    48'hC2865D_3D79A2
  };

  typedef enum logic [1:0] {FIND_1ST, COUNT_2, LOCKED} am_state_e;

  // Place the 48 pattern bits on their byte lanes, BIP bytes zero.
  function automatic logic [DATA_W-1:0] am_expand(input logic [47:0] pat);
    return {8'h00, pat[47:24], 8'h00, pat[23:0]};
  endfunction

  // Index of the set bit of a one-hot lane vector (0 when empty).
  function automatic logic [LANE_W-1:0] onehot_idx(input logic [LANE_N-1:0] vec);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LANE_N; i++) begin
      if (vec[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alignement_marker_lane_rx_if.sv
// Block stream into and out of the per-lane AM lock block.
// There is no back-pressure: valid_i qualifies head_i/data_i for one cycle,
// and valid_o qualifies head_o/data_o/marker_v_o one cycle later.
interface alignement_marker_lane_rx_if;
  import alignement_marker_pkg::*;

  logic              block_lock_i;
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;
  logic              marker_v_o;
  logic              am_lock_o;
  logic [LANE_W-1:0] lane_id_o;
  am_state_e         state_dbg;

  modport master (
    output block_lock_i, valid_i, head_i, data_i,
    input  valid_o, head_o, data_o, marker_v_o, am_lock_o, lane_id_o, state_dbg
  );

  modport slave (
    input  block_lock_i, valid_i, head_i, data_i,
    output valid_o, head_o, data_o, marker_v_o, am_lock_o, lane_id_o, state_dbg
  );
endinterface

// File: rtl/alignement_marker_match.sv
// Combinational lane-marker detector: one-hot hit per lane pattern, BIP bytes ignored.
module alignement_marker_match
  import alignement_marker_pkg::*;
(
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [LANE_N-1:0] match_o
);

  // Compare the masked payload against every lane pattern.
  always_comb begin
    match_o = '0;
    for (int l = 0; l < LANE_N; l++) begin
      match_o[l] = (head_i == AM_SYNC_HEAD) &&
                   ((data_i & ~AM_BIP_MASK) == am_expand(AM_PATTERN[l]));
    end
  end

endmodule

// File: rtl/alignement_marker_lane_rx.sv
// Per-lane alignment-marker lock: hunt, confirm one period later, flag markers while locked.
module alignement_marker_lane_rx
  import alignement_marker_pkg::*;
#(
  parameter int AM_PERIOD = AM_PERIOD_DEF,
  parameter int CNT_W     = $clog2(AM_PERIOD),
  parameter int INVLD_MAX = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  alignement_marker_lane_rx_if.slave bus
);

  localparam int               INV_W    = $clog2(INVLD_MAX + 1);
  localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVLD_MAX - 1);

  am_state_e         state_q, state_d;
  logic [CNT_W-1:0]  pos_q, pos_d;
  logic [INV_W-1:0]  invld_q, invld_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              valid_q, valid_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              marker_v_q, marker_v_d;
  logic [LANE_N-1:0] match;
  logic              hit_lane;
  logic              at_last;

  alignement_marker_match u_match (
    .head_i  (bus.head_i),
    .data_i  (bus.data_i),
    .match_o (match)
  );

  assign hit_lane = match[lane_q];
  assign at_last  = (pos_q == POS_LAST);

  // Next-state, counters and registered datapath; only valid blocks advance the FSM.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    invld_d    = invld_q;
    lane_d     = lane_q;
    marker_v_d = 1'b0;
    valid_d    = bus.valid_i;
    head_d     = bus.head_i;
    data_d     = bus.data_i;
    if (!bus.block_lock_i) begin
      // Loss of block sync beats everything, including a marker this cycle.
      state_d = FIND_1ST;
      pos_d   = '0;
      invld_d = '0;
    end else if (bus.valid_i) begin
      case (state_q)
        FIND_1ST: begin
          if (|match) begin
            lane_d  = onehot_idx(match);
            pos_d   = '0;
            state_d = COUNT_2;
          end
        end
        COUNT_2: begin
          if (at_last) begin
            pos_d = '0;
            if (hit_lane) begin
              state_d    = LOCKED;
              invld_d    = '0;
              marker_v_d = 1'b1;
            end else begin
              // The failed block is not reconsidered as a first marker.
              state_d = FIND_1ST;
            end
          end else begin
            pos_d = pos_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (at_last) begin
            pos_d      = '0;
            marker_v_d = 1'b1;
            if (hit_lane) begin
              invld_d = '0;
            end else if (invld_q == INV_LAST) begin
              state_d = FIND_1ST;
              invld_d = '0;
            end else begin
              invld_d = invld_q + INV_W'(1);
            end
          end else begin
            pos_d = pos_q + CNT_W'(1);
          end
        end
        default: state_d = FIND_1ST;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FIND_1ST;
      pos_q      <= '0;
      invld_q    <= '0;
      lane_q     <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      data_q     <= '0;
      marker_v_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      invld_q    <= invld_d;
      lane_q     <= lane_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      data_q     <= data_d;
      marker_v_q <= marker_v_d;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.head_o     = head_q;
  assign bus.data_o     = data_q;
  assign bus.marker_v_o = marker_v_q;
  assign bus.am_lock_o  = (state_q == LOCKED);
  assign bus.lane_id_o  = lane_q;
  assign bus.state_dbg  = state_q;

endmodule
